mux_arbiter: RTL and testbench
==============================

# mux_arbiter

Round-robin arbiter that shares the 8-bit 4:1 data multiplexer among four requesters. Each requester raises a request line; the arbiter grants one requester at a time and drives the multiplexer select so that requester's byte reaches the shared output. A per-grant hold limit bounds how long one requester can own the path while others wait. It sits directly in front of the mux select input. Requester data buses connect to mux inputs a/b/c/d in index order 0..3.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles a grant is held while any other request is pending; legal range 1..15.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  request per requester; bit i maps to mux input i (0=a, 1=b, 2=c, 3=d)
- grant  output  4  one-hot grant (registered); all-zero when idle
- sel  output  2  mux select (registered); equals index of granted requester
- busy  output  1  high while any grant is asserted

## Operation
- Internal state: FSM {IDLE, BUSY}, 2-bit last-served pointer `last`, 4-bit hold counter `hold`.
- Rotation search: from a start index s, pick the first i in order s, s+1, s+2, s+3 (mod 4) with the candidate request set. The candidate set is req with the current owner's bit masked when searching for a successor.
- IDLE:
  - grant=0, busy=0, sel holds its last value.
  - If req!=0, search from last+1. Next edge: grant the winner w, sel=w, last=w, hold=0, enter BUSY.
- BUSY, owner g:
  - grant=1<<g, sel=g, busy=1.
  - Each edge with req[g]=1 and no other request: stay. hold increments, saturating at MAX_HOLD-1.
  - Each edge with req[g]=1, others pending, and hold<MAX_HOLD-1: stay, hold+1.
  - Each edge with req[g]=1, others pending, and hold==MAX_HOLD-1: forced switch to the successor (search from g+1, owner excluded).
  - Each edge with req[g]=0 and others pending: switch to the successor in the same edge, with no idle cycle.
  - Each edge with req[g]=0 and no others: enter IDLE, grant=0.
  - On every switch: last=new owner, hold=0.
- MAX_HOLD=1: owner switches every cycle while contention exists.
- Invariants:
  - grant is zero or one-hot.
  - sel==index of set grant bit whenever busy=1.
  - Grants are never given to a requester whose req was low at the deciding edge.
- Requesters must keep req high until granted. Dropping req before grant is legal; it simply withdraws the request.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, grant=4'b0000, sel=2'b00, busy=0, last=2'b11, hold=0. With last=3, the first arbitration after reset starts at requester 0.
- Reset mid-grant clears grant/busy immediately, without waiting for a clock edge. After release, arbitration restarts from requester 0.
- Grant latency:
  - 1 cycle from req sampled high in IDLE to grant/sel valid.
  - Handover between owners is 0 idle cycles: the old grant falls and the new grant rises on the same edge.
- Release latency: grant falls on the first edge at which req[g] is sampled low.
- Mux output is combinational from sel. The data byte for owner g is valid in every cycle grant[g]=1.
- Worst-case wait for a continuously requesting requester: 3*MAX_HOLD cycles after it raises req while others hold the path. It may additionally wait the 1-cycle decision latency.

## Test plan
- Reset/idle: assert rst_n=0 mid-BUSY with grant=0100 → grant=0000, sel=00, busy=0 without a clock edge. After release, req=1111 → grant=0001 on the next edge.
- Single requester: req=0100 for 10 cycles, then 0000 → grant=0100 and sel=10 from cycle 1 to cycle 10. No forced rotation occurs. grant=0000 the edge after req falls.
- Full contention, MAX_HOLD=4, req=1111 held → grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles. sel follows 00, 01, 10, 11, 00.
- Early release handover: owner 1 (grant=0010) drops req while req[3] is high → grant=1000 and sel=11 on the same edge; busy stays 1.
- Rotation fairness: owner 2 releases while req=0011 → next grant is 0001, the first requester after 2 in rotation order (search wraps 3→0).
- MAX_HOLD=1 with req=0101 → grant alternates 0001/0100 every cycle. Grant is always one-hot, and sel always matches the granted index.

Source files
------------

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter owning the select of a shared 8-bit 4:1
// data multiplexer. Requester i drives mux input i (0=a, 1=b, 2=c, 3=d).
// A grant is held for at most MAX_HOLD consecutive cycles while any other
// requester is waiting. Release hands over to the next waiting requester on
// the same edge, with no idle cycle in between.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [3:0] request lines, bit i = requester i
//   grant  out  [3:0] registered one-hot grant, zero when idle
//   sel    out  [1:0] registered mux select = index of granted requester
//   busy   out  high while any grant is asserted
module mux_arbiter #(
    parameter int unsigned MAX_HOLD = 4  // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [1:0] last;
    logic [3:0] hold;

    logic [3:0] hold_max;
    logic [3:0] others;
    logic [2:0] idle_pick;
    logic [2:0] succ_pick;
    logic       do_switch;
    logic       go_idle;
    logic       hold_inc;

    // Returns {found, index} of the first set bit of cand, scanning
    // start, start+1, ... modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand,
                                           input logic [1:0] start);
        logic       found;
        logic [1:0] idx;
        logic [1:0] win;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    assign hold_max = 4'(MAX_HOLD - 1);

    always_comb begin
        // In BUSY the owner index is sel; mask it when looking for a successor.
        others    = req & ~(4'b0001 << sel);
        idle_pick = rr_pick(req, last + 2'd1);
        succ_pick = rr_pick(others, sel + 2'd1);
        do_switch = 1'b0;
        go_idle   = 1'b0;
        hold_inc  = 1'b0;
        if (req[sel]) begin
            if (!succ_pick[2]) begin
                hold_inc = (hold < hold_max);  // saturate when alone
            end else if (hold < hold_max) begin
                hold_inc = 1'b1;
            end else begin
                do_switch = 1'b1;              // hold limit reached
            end
        end else if (succ_pick[2]) begin
            do_switch = 1'b1;                  // release with others waiting
        end else begin
            go_idle = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            last  <= 2'b11;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[2]) begin
                        state <= BUSY;
                        grant <= 4'b0001 << idle_pick[1:0];
                        sel   <= idle_pick[1:0];
                        last  <= idle_pick[1:0];
                        hold  <= '0;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (do_switch) begin
                        grant <= 4'b0001 << succ_pick[1:0];
                        sel   <= succ_pick[1:0];
                        last  <= succ_pick[1:0];
                        hold  <= '0;
                    end else if (go_idle) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (hold_inc) begin
                        hold <= hold + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Testbench for mux_arbiter: directed request vectors with hand-computed
// expected grant/sel/busy. The driver pushes expectations into per-DUT
// queues; monitors pop and compare one cycle later, after each rising edge.
// Two instances: default MAX_HOLD=4 and MAX_HOLD=1.
module tb_mux_arbiter;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] grant_a, grant_b;
    logic [1:0] sel_a, sel_b;
    logic       busy_a, busy_b;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    mux_arbiter dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .grant(grant_a), .sel(sel_a), .busy(busy_a)
    );

    mux_arbiter #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .grant(grant_b), .sel(sel_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e, input logic [3:0] g,
                                 input logic [1:0] s, input logic b);
        logic [1:0] idx;
        cmp({e.name, "/grant"}, {4'b0, g}, {4'b0, e.grant});
        cmp({e.name, "/sel"},   {6'b0, s}, {6'b0, e.sel});
        cmp({e.name, "/busy"},  {7'b0, b}, {7'b0, e.busy});
        cmp({e.name, "/onehot0"}, {7'b0, $onehot0(g)}, 8'd1);
        if (b) begin
            idx = '0;
            for (int i = 0; i < 4; i++) if (g[i]) idx = 2'(i);
            cmp({e.name, "/sel_vs_grant"}, {6'b0, s}, {6'b0, idx});
        end
    endtask

    // Drive req for the next edge and queue the state expected after it.
    task automatic step(input bit which, input logic [3:0] r,
                        input logic [3:0] g, input logic [1:0] s,
                        input logic b, input string name);
        exp_t e;
        @(negedge clk);
        e.grant = g; e.sel = s; e.busy = b; e.name = name;
        if (!which) begin
            req_a = r;
            q_a.push_back(e);
        end else begin
            req_b = r;
            q_b.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check_outputs(e, grant_a, sel_a, busy_a);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check_outputs(e, grant_b, sel_b, busy_b);
            end
        end
    end

    initial begin : driver
        logic [3:0] g;
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        cmp("reset/grant", {4'b0, grant_a}, 8'h00);
        cmp("reset/sel",   {6'b0, sel_a},   8'h00);
        cmp("reset/busy",  {7'b0, busy_a},  8'h00);
        cmp("reset_b/grant", {4'b0, grant_b}, 8'h00);
        rst_n = 1'b1;

        // Single requester: held 10 cycles with no forced rotation.
        for (int i = 0; i < 10; i++) step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, "single");
        step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_release");
        step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_idle");

        // Asynchronous reset in the middle of a grant.
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, "pre_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req_a = 4'b0000;
        #1;
        cmp("async_reset/grant", {4'b0, grant_a}, 8'h00);
        cmp("async_reset/sel",   {6'b0, sel_a},   8'h00);
        cmp("async_reset/busy",  {7'b0, busy_a},  8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Full contention: 0001,0010,0100,1000,0001, four cycles each.
        for (int k = 0; k < 20; k++) begin
            g = 4'b0001 << ((k / 4) % 4);
            step(0, 4'b1111, g, 2'((k / 4) % 4), 1'b1, "contention");
        end

        // Forced switch to 1, then 1 releases while 3 waits.
        step(0, 4'b1111, 4'b0010, 2'd1, 1'b1, "to_owner1");
        step(0, 4'b1000, 4'b1000, 2'd3, 1'b1, "early_release");
        // Owner 3 releases to 2; owner 2 releases with 0011 pending -> wraps to 0.
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, "to_owner2");
        step(0, 4'b0011, 4'b0001, 2'd0, 1'b1, "wrap_fair");
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "to_idle");

        // Hold saturates while alone; a newcomer then forces an immediate switch.
        for (int i = 0; i < 6; i++) step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, "saturate");
        step(0, 4'b0011, 4'b0010, 2'd1, 1'b1, "sat_switch");
        step(0, 4'b0000, 4'b0000, 2'd1, 1'b0, "sat_idle");

        // MAX_HOLD=1: alternate every cycle.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) step(1, 4'b0101, 4'b0001, 2'd0, 1'b1, "mh1_alt");
            else            step(1, 4'b0101, 4'b0100, 2'd2, 1'b1, "mh1_alt");
        end
        step(1, 4'b0000, 4'b0000, 2'd2, 1'b0, "mh1_idle");

        for (int i = 0; i < 5 && (q_a.size() > 0 || q_b.size() > 0); i++) @(posedge clk);
        #2;
        cmp("queue_drain", 8'(q_a.size() + q_b.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
